uart_buffer_ctrl: RTL

//  Ring-buffer controller and port arbiter for the UART's shared 512x8 buffer RAM.
//  TX ring occupies RAM[0..255]; RX ring occupies RAM[256..511].
//  It shares the single read port between user RX reads and TX drain, and the single write port between RX stores and user TX writes.
//  It tracks counts, full/empty and overflow, and sequences tx strobes. It sits between the user bus, uart_tx/uart_rx and uart_ram.

---
 rtl/uart_buffer_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_buffer_ctrl.sv
// Ring-buffer controller and port arbiter for the UART's shared 512x8 RAM.
// TX ring lives in the lower half of the RAM, RX ring in the upper half.
// One read port is shared by user RX reads and the TX drain sequencer; one
// write port is shared by RX stores (fixed priority) and user TX writes.
module uart_buffer_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_user_re,
  output logic              o_user_rack,
  output logic              o_user_rvalid,
  output logic [7:0]        o_user_rdata,
  input  logic              i_user_we,
  input  logic [7:0]        i_user_wdata,
  output logic              o_user_wack,
  input  logic              i_clear_flags,
  output logic [ADDR_W:0]   o_rx_count,
  output logic [ADDR_W:0]   o_tx_count,
  output logic              o_rx_empty,
  output logic              o_tx_full,
  output logic              o_rx_overflow,
  output logic              o_tx_overflow,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_strobe,
  input  logic              i_tx_busy,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_new,
  output logic              o_rx_ack,
  output logic [ADDR_W:0]   o_ram_r_addr,
  input  logic [7:0]        i_ram_r_data,
  output logic [ADDR_W:0]   o_ram_w_addr,
  output logic [7:0]        o_ram_w_data,
  output logic              o_ram_we
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_DATA, TX_HOLD} tx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [ADDR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [ADDR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [ADDR_W:0]   rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic              rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic              rr_tx_q, rr_tx_d;
  logic              user_rvalid_q, user_rvalid_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic user_elig, tx_elig, user_grant, tx_grant;
  logic rx_store, rx_drop, tx_store, tx_drop;
  logic rx_full, tx_full;

  assign rx_full   = (rx_count_q == FULL_CNT);
  assign tx_full   = (tx_count_q == FULL_CNT);
  assign user_elig = i_user_re && (rx_count_q != '0);
  assign tx_elig   = (tx_state_q == TX_REQ);

  // Read-port arbitration: round-robin only when both requesters contend
  always_comb begin
    user_grant   = 1'b0;
    tx_grant     = 1'b0;
    rr_tx_d      = rr_tx_q;
    o_ram_r_addr = '0;
    if (!i_reset) begin
      if (user_elig && tx_elig) begin
        user_grant = !rr_tx_q;
        tx_grant   = rr_tx_q;
        rr_tx_d    = !rr_tx_q;
      end else begin
        user_grant = user_elig;
        tx_grant   = tx_elig;
      end
    end
    if (user_grant)
      o_ram_r_addr = {1'b1, rx_rd_q};
    else if (tx_grant)
      o_ram_r_addr = {1'b0, tx_rd_q};
  end

  // Write-port arbitration: RX store beats user write; drops still ack
  always_comb begin
    rx_store     = 1'b0;
    rx_drop      = 1'b0;
    tx_store     = 1'b0;
    tx_drop      = 1'b0;
    o_ram_we     = 1'b0;
    o_ram_w_addr = '0;
    o_ram_w_data = '0;
    o_rx_ack     = 1'b0;
    o_user_wack  = 1'b0;
    if (!i_reset) begin
      if (i_rx_new) begin
        o_rx_ack = 1'b1;
        if (!rx_full) begin
          rx_store     = 1'b1;
          o_ram_we     = 1'b1;
          o_ram_w_addr = {1'b1, rx_wr_q};
          o_ram_w_data = i_rx_data;
        end else begin
          rx_drop = 1'b1;
        end
      end else if (i_user_we) begin
        o_user_wack = 1'b1;
        if (!tx_full) begin
          tx_store     = 1'b1;
          o_ram_we     = 1'b1;
          o_ram_w_addr = {1'b0, tx_wr_q};
          o_ram_w_data = i_user_wdata;
        end else begin
          tx_drop = 1'b1;
        end
      end
    end
  end

  // Pointer, count, flag and TX sequencer next-state
  always_comb begin
    rx_wr_d       = rx_store   ? rx_wr_q + PTR_ONE : rx_wr_q;
    rx_rd_d       = user_grant ? rx_rd_q + PTR_ONE : rx_rd_q;
    tx_wr_d       = tx_store   ? tx_wr_q + PTR_ONE : tx_wr_q;
    tx_rd_d       = tx_grant   ? tx_rd_q + PTR_ONE : tx_rd_q;
    rx_count_d    = rx_count_q + (ADDR_W+1)'(rx_store) - (ADDR_W+1)'(user_grant);
    tx_count_d    = tx_count_q + (ADDR_W+1)'(tx_store) - (ADDR_W+1)'(tx_grant);
    rx_ovf_d      = (rx_ovf_q && !i_clear_flags) || rx_drop;
    tx_ovf_d      = (tx_ovf_q && !i_clear_flags) || tx_drop;
    user_rvalid_d = user_grant;
    tx_data_d     = tx_data_q;
    tx_state_d    = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if ((tx_count_q != '0) && !i_tx_busy) tx_state_d = TX_REQ;
      TX_REQ:  if (tx_grant) tx_state_d = TX_DATA;
      TX_DATA: begin
        tx_data_d  = i_ram_r_data;
        tx_state_d = TX_HOLD;
      end
      // Guard cycle so the busy rise from uart_tx is seen before re-arming
      TX_HOLD: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state_q    <= TX_IDLE;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      rx_count_q    <= '0;
      tx_count_q    <= '0;
      rx_ovf_q      <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rr_tx_q       <= 1'b0;
      user_rvalid_q <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      rx_count_q    <= rx_count_d;
      tx_count_q    <= tx_count_d;
      rx_ovf_q      <= rx_ovf_d;
      tx_ovf_q      <= tx_ovf_d;
      rr_tx_q       <= rr_tx_d;
      user_rvalid_q <= user_rvalid_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign o_user_rack   = user_grant;
  assign o_user_rvalid = user_rvalid_q;
  assign o_user_rdata  = user_rvalid_q ? i_ram_r_data : 8'h00;
  assign o_rx_count    = rx_count_q;
  assign o_tx_count    = tx_count_q;
  assign o_rx_empty    = (rx_count_q == '0);
  assign o_tx_full     = tx_full;
  assign o_rx_overflow = rx_ovf_q;
  assign o_tx_overflow = tx_ovf_q;
  // The fetched byte is visible in the same cycle as the strobe
  assign o_tx_data     = (tx_state_q == TX_DATA) ? i_ram_r_data : tx_data_q;
  assign o_tx_strobe   = (tx_state_q == TX_DATA) && !i_reset;

endmodule
